// File: rtl/data_sram_like_bridge_if.sv
// sram-like data bus between the MEM-stage bridge (master) and the AXI bridge (slave).
// Split transaction: req/addr_ok accepts the request, data_ok completes it.
interface data_sram_like_bridge_if;
  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size_o;
  logic [31:0] data_addr_o;
  logic [31:0] data_wdata_o;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata_i;

  modport master (
    output data_req, data_wr, data_size_o, data_addr_o, data_wdata_o,
    input  data_addr_ok, data_data_ok, data_rdata_i
  );

  modport slave (
    input  data_req, data_wr, data_size_o, data_addr_o, data_wdata_o,
    output data_addr_ok, data_data_ok, data_rdata_i
  );
endinterface

// File: rtl/data_sram_like_bridge.sv
// Converts the one-cycle SRAM-style MEM-stage data access into a split sram-like
// transaction, stalls the pipeline meanwhile and holds the load result until release.
module data_sram_like_bridge #(
  parameter bit MAP_KSEG = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        data_en,
  input  logic [3:0]  data_wen,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic [31:0] data_rdata,
  output logic        d_stall,
  input  logic        longest_stall,
  data_sram_like_bridge_if.master bus
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_e;

  state_e      state_q;
  logic        wr_q;
  logic [1:0]  size_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;

  logic        use_latch;
  logic        cur_wr;
  logic [1:0]  cur_size;
  logic [31:0] cur_addr;
  logic [31:0] cur_wdata;
  logic        addr_ok_now;
  logic        data_ok_now;

  function automatic logic [31:0] map_addr(input logic [31:0] a);
    // kseg0/kseg1 (top bits 100/101) fold onto the low 512 MB physical window
    if (MAP_KSEG && (a[31:30] == 2'b10)) return {3'b000, a[28:0]};
    return a;
  endfunction

  always_comb begin
    use_latch = (state_q != IDLE);
    cur_wr    = use_latch ? wr_q    : (|data_wen);
    cur_size  = use_latch ? size_q  : data_size;
    cur_addr  = use_latch ? addr_q  : data_addr;
    cur_wdata = use_latch ? wdata_q : data_wdata;

    bus.data_req     = ((state_q == IDLE) && data_en) || (state_q == REQ);
    bus.data_wr      = cur_wr;
    bus.data_size_o  = cur_size;
    bus.data_addr_o  = map_addr(cur_addr);
    bus.data_wdata_o = cur_wdata;

    addr_ok_now = bus.data_req && bus.data_addr_ok;
    // data_ok only counts once the request has been (or is being) accepted
    data_ok_now = bus.data_data_ok && (addr_ok_now || (state_q == WAIT));

    d_stall    = data_en && (state_q != DONE);
    data_rdata = rdata_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      wr_q    <= 1'b0;
      size_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      if (data_ok_now && !cur_wr) rdata_q <= bus.data_rdata_i;

      unique case (state_q)
        IDLE: begin
          if (data_en) begin
            wr_q    <= |data_wen;
            size_q  <= data_size;
            addr_q  <= data_addr;
            wdata_q <= data_wdata;
            if (addr_ok_now && data_ok_now) state_q <= DONE;
            else if (addr_ok_now)           state_q <= WAIT;
            else                            state_q <= REQ;
          end
        end
        REQ: begin
          if (addr_ok_now && data_ok_now) state_q <= DONE;
          else if (addr_ok_now)           state_q <= WAIT;
        end
        WAIT: begin
          if (data_ok_now) state_q <= DONE;
        end
        DONE: begin
          if (!longest_stall) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_sram_like_bridge.sv
// Directed bench for data_sram_like_bridge: kseg-mapping instance plus a pass-through
// instance driven by identical stimulus.
module tb_data_sram_like_bridge;

  logic        clk;
  logic        rst;
  logic        data_en;
  logic [3:0]  data_wen;
  logic [1:0]  data_size;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        longest_stall;
  logic [31:0] data_rdata, data_rdata2;
  logic        d_stall, d_stall2;

  int unsigned n_tests;
  int unsigned n_fail;

  data_sram_like_bridge_if bus1();
  data_sram_like_bridge_if bus2();

  assign bus2.data_addr_ok = bus1.data_addr_ok;
  assign bus2.data_data_ok = bus1.data_data_ok;
  assign bus2.data_rdata_i = bus1.data_rdata_i;

  data_sram_like_bridge #(.MAP_KSEG(1'b1)) dut (
    .clk(clk), .rst(rst),
    .data_en(data_en), .data_wen(data_wen), .data_size(data_size),
    .data_addr(data_addr), .data_wdata(data_wdata),
    .data_rdata(data_rdata), .d_stall(d_stall), .longest_stall(longest_stall),
    .bus(bus1.master)
  );

  data_sram_like_bridge #(.MAP_KSEG(1'b0)) dut_nomap (
    .clk(clk), .rst(rst),
    .data_en(data_en), .data_wen(data_wen), .data_size(data_size),
    .data_addr(data_addr), .data_wdata(data_wdata),
    .data_rdata(data_rdata2), .d_stall(d_stall2), .longest_stall(longest_stall),
    .bus(bus2.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  // One read completed in the request cycle, released on the following cycle.
  task automatic single_read(input logic [31:0] addr, input logic [31:0] rd,
                             input logic [31:0] exp_map, input logic [31:0] exp_nomap);
    data_en = 1'b1; data_wen = 4'b0000; data_size = 2'd2; data_addr = addr;
    bus1.data_addr_ok = 1'b1; bus1.data_data_ok = 1'b1; bus1.data_rdata_i = rd;
    longest_stall = 1'b1;
    settle();
    check("rd_req", {31'd0, bus1.data_req}, 32'd1);
    check("rd_stall", {31'd0, d_stall}, 32'd1);
    check("rd_addr_map", bus1.data_addr_o, exp_map);
    check("rd_addr_nomap", bus2.data_addr_o, exp_nomap);
    tick();
    bus1.data_addr_ok = 1'b0; bus1.data_data_ok = 1'b0; bus1.data_rdata_i = '0;
    longest_stall = 1'b0;
    settle();
    check("rd_done_stall", {31'd0, d_stall}, 32'd0);
    check("rd_data", data_rdata, rd);
    check("rd_data_nomap", data_rdata2, rd);
    tick();
    data_en = 1'b0;
  endtask

  initial begin
    n_tests = 0; n_fail = 0;
    rst = 1'b1;
    data_en = 1'b0; data_wen = '0; data_size = '0; data_addr = '0; data_wdata = '0;
    longest_stall = 1'b0;
    bus1.data_addr_ok = 1'b0; bus1.data_data_ok = 1'b0; bus1.data_rdata_i = '0;
    #1 rst = 1'b0;
    settle();
    check("rst_req", {31'd0, bus1.data_req}, 32'd0);
    check("rst_stall", {31'd0, d_stall}, 32'd0);
    check("rst_rdata", data_rdata, 32'd0);
    tick(); tick();
    rst = 1'b1;

    // 1: word load, addr_ok in cycle 0, data_ok in cycle 2
    data_en = 1'b1; data_wen = 4'b0000; data_size = 2'd2; data_addr = 32'h8000_1000;
    bus1.data_addr_ok = 1'b1; longest_stall = 1'b1;
    settle();
    check("t1_req", {31'd0, bus1.data_req}, 32'd1);
    check("t1_addr", bus1.data_addr_o, 32'h0000_1000);
    check("t1_addr_nomap", bus2.data_addr_o, 32'h8000_1000);
    check("t1_size", {30'd0, bus1.data_size_o}, 32'd2);
    check("t1_wr", {31'd0, bus1.data_wr}, 32'd0);
    check("t1_stall_c0", {31'd0, d_stall}, 32'd1);
    tick();
    bus1.data_addr_ok = 1'b0;
    settle();
    check("t1_req_c1", {31'd0, bus1.data_req}, 32'd0);
    check("t1_stall_c1", {31'd0, d_stall}, 32'd1);
    tick();
    bus1.data_data_ok = 1'b1; bus1.data_rdata_i = 32'hDEAD_BEEF;
    settle();
    check("t1_stall_c2", {31'd0, d_stall}, 32'd1);
    tick();
    bus1.data_data_ok = 1'b0; bus1.data_rdata_i = '0; longest_stall = 1'b0;
    settle();
    check("t1_stall_c3", {31'd0, d_stall}, 32'd0);
    check("t1_rdata", data_rdata, 32'hDEAD_BEEF);
    check("t1_req_c3", {31'd0, bus1.data_req}, 32'd0);
    tick();
    data_en = 1'b0;
    settle();
    check("t1_idle_req", {31'd0, bus1.data_req}, 32'd0);

    // 2: half-word store, addr_ok withheld 3 cycles; core inputs scrambled meanwhile
    data_en = 1'b1; data_wen = 4'b1100; data_size = 2'd1; data_addr = 32'h9000_0002;
    data_wdata = 32'hAABB_0000; longest_stall = 1'b1;
    settle();
    check("t2_req_c0", {31'd0, bus1.data_req}, 32'd1);
    check("t2_wr_c0", {31'd0, bus1.data_wr}, 32'd1);
    tick();
    for (int i = 1; i <= 3; i++) begin
      data_wen = 4'b0000; data_size = 2'd2; data_addr = 32'hFFFF_FFFC; data_wdata = '0;
      bus1.data_addr_ok = (i == 3);
      settle();
      check("t2_req_hold", {31'd0, bus1.data_req}, 32'd1);
      check("t2_wr_hold", {31'd0, bus1.data_wr}, 32'd1);
      check("t2_addr_hold", bus1.data_addr_o, 32'h1000_0002);
      check("t2_wdata_hold", bus1.data_wdata_o, 32'hAABB_0000);
      check("t2_size_hold", {30'd0, bus1.data_size_o}, 32'd1);
      tick();
    end
    bus1.data_addr_ok = 1'b0; bus1.data_data_ok = 1'b1; bus1.data_rdata_i = 32'h1234_5678;
    settle();
    check("t2_req_wait", {31'd0, bus1.data_req}, 32'd0);
    check("t2_stall_wait", {31'd0, d_stall}, 32'd1);
    tick();
    bus1.data_data_ok = 1'b0; bus1.data_rdata_i = '0; longest_stall = 1'b0;
    settle();
    check("t2_stall_done", {31'd0, d_stall}, 32'd0);
    check("t2_rdata_kept", data_rdata, 32'hDEAD_BEEF);
    tick();
    data_en = 1'b0;

    // 3: addr_ok and data_ok together with data_en
    single_read(32'h0000_2000, 32'hCAFE_F00D, 32'h0000_2000, 32'h0000_2000);

    // 4: data returns while the instruction side keeps the pipeline stalled
    data_en = 1'b1; data_wen = 4'b0000; data_size = 2'd2; data_addr = 32'hA000_0010;
    bus1.data_addr_ok = 1'b1; bus1.data_data_ok = 1'b1; bus1.data_rdata_i = 32'h1111_2222;
    longest_stall = 1'b1;
    settle();
    tick();
    for (int i = 0; i < 4; i++) begin
      bus1.data_addr_ok = 1'b0; bus1.data_data_ok = 1'b0; bus1.data_rdata_i = 32'h9999_9999;
      settle();
      check("t4_no_req", {31'd0, bus1.data_req}, 32'd0);
      check("t4_stall", {31'd0, d_stall}, 32'd0);
      check("t4_rdata_held", data_rdata, 32'h1111_2222);
      tick();
    end
    longest_stall = 1'b0;
    settle();
    check("t4_release_req", {31'd0, bus1.data_req}, 32'd0);
    tick();
    data_addr = 32'h0000_0020;
    settle();
    check("t4_new_req", {31'd0, bus1.data_req}, 32'd1);
    check("t4_new_stall", {31'd0, d_stall}, 32'd1);
    tick();
    bus1.data_addr_ok = 1'b1; bus1.data_data_ok = 1'b1; bus1.data_rdata_i = 32'h3333_4444;
    settle();
    tick();
    bus1.data_addr_ok = 1'b0; bus1.data_data_ok = 1'b0; bus1.data_rdata_i = '0;
    settle();
    check("t4_new_rdata", data_rdata, 32'h3333_4444);
    tick();
    data_en = 1'b0;

    // 5: reset while waiting for data, then a stale data_ok
    data_en = 1'b1; data_addr = 32'h8000_0040; bus1.data_addr_ok = 1'b1; longest_stall = 1'b1;
    settle();
    tick();
    bus1.data_addr_ok = 1'b0;
    settle();
    check("t5_wait_req", {31'd0, bus1.data_req}, 32'd0);
    rst = 1'b0;
    #1;
    check("t5_rst_stall_en", {31'd0, d_stall}, 32'd1);
    check("t5_rst_rdata", data_rdata, 32'd0);
    data_en = 1'b0;
    #1;
    check("t5_rst_req", {31'd0, bus1.data_req}, 32'd0);
    check("t5_rst_stall", {31'd0, d_stall}, 32'd0);
    tick();
    rst = 1'b1;
    bus1.data_data_ok = 1'b1; bus1.data_rdata_i = 32'h5555_5555;
    settle();
    check("t5_late_req", {31'd0, bus1.data_req}, 32'd0);
    tick();
    bus1.data_data_ok = 1'b0; bus1.data_rdata_i = '0;
    settle();
    check("t5_late_rdata", data_rdata, 32'd0);
    check("t5_late_stall", {31'd0, d_stall}, 32'd0);
    single_read(32'h0000_0080, 32'h7777_8888, 32'h0000_0080, 32'h0000_0080);

    // 6: MAP_KSEG=0 pass-through and segment boundaries
    single_read(32'hA000_0004, 32'h0BAD_C0DE, 32'h0000_0004, 32'hA000_0004);
    single_read(32'h6000_0000, 32'h0102_0304, 32'h6000_0000, 32'h6000_0000);
    single_read(32'hC000_0008, 32'h0506_0708, 32'hC000_0008, 32'hC000_0008);
    single_read(32'hBFFF_FFFC, 32'h090A_0B0C, 32'h1FFF_FFFC, 32'hBFFF_FFFC);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
